lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

- Downstream consumer of the memory-mapped LCD register (`io_buffer[4]` at 0x1000_4xxx, exported as `o_io_lcd`).
- Converts changes of that 32-bit register into correctly timed HD44780-style write cycles on the LCD pins (setup, EN pulse, hold, execution wait).
- Buffers one pending command while a transaction is in flight, keeping the newest.
- Counts commands overwritten before they were issued.

## Interface

Parameters:
- `T_SETUP`, 2: cycles RS/DATA are stable before EN rises (≥1).
- `T_EN`, 12: cycles EN is high (≥1).
- `T_HOLD`, 2: cycles RS/DATA are held after EN falls (≥1).
- `T_EXEC`, 2000: LCD execution wait after hold (≥1).

Ports:
- `i_clk`  in  1: global clock.
- `i_reset`  in  1: global reset. Asynchronous, active-low.
- `i_io_lcd`  in  32: LCD register. [7:0] data, [8] RS, [30:9] ignored, [31] ON.
- `o_lcd_data`  out  8: LCD data bus.
- `o_lcd_rs`  out  1: register select.
- `o_lcd_rw`  out  1: read/write. Constant 0 (write-only).
- `o_lcd_en`  out  1: enable strobe.
- `o_lcd_on`  out  1: panel power/backlight. Registered copy of `i_io_lcd[31]`.
- `o_busy`  out  1: high when state≠IDLE or a command is pending.
- `o_ovf_cnt`  out  8: saturating count of overwritten pending commands.

## Operation

- **Command and change detection:** command = {RS, data} = `i_io_lcd[8:0]`.
  - `last_seen` (9 bits) updates every cycle.
  - A change is flagged when `i_io_lcd[8:0]` ≠ `last_seen`.
  - Bits [30:9] never trigger anything.
- **Pending slot (1 entry):** on a change, `pend` ← new cmd and `pend_v` ← 1.
  - If `pend_v` was already 1 and not consumed that cycle: the old entry is overwritten and `o_ovf_cnt` += 1, saturating at 255.
  - Consume and capture in the same cycle: the new cmd enters the slot, no overflow.
- **ON handling:** `o_lcd_on` ← `i_io_lcd[31]` every cycle.
  - While ON=0, changes still update `last_seen` but are not captured, and `pend_v` is cleared.
  - ON dropping mid-transaction: the current transaction runs to IDLE; the pending entry is dropped.
  - ON 0→1 does not issue a command by itself.
- **FSM states:** IDLE, SETUP, PULSE, HOLD, EXEC. A down-counter is sized for the maximum parameter.
  - IDLE: if `pend_v` and ON, load `o_lcd_data`/`o_lcd_rs` from `pend`, clear `pend_v`, go to SETUP with counter = `T_SETUP`-1.
  - SETUP: EN=0. When counter = 0, go to PULSE with `T_EN`-1.
  - PULSE: EN=1. When counter = 0, go to HOLD with `T_HOLD`-1.
  - HOLD: EN=0. When counter = 0, go to EXEC with `T_EXEC`-1.
  - EXEC: EN=0. When counter = 0, go to IDLE.
- **Output behaviour:**
  - `o_lcd_data`/`o_lcd_rs` change only on the IDLE→SETUP transition and otherwise hold their last value.
  - `o_lcd_en` is a registered output, high exactly in PULSE.
- **Reset:** asynchronous, active-low, effective immediately including mid-transaction (EN drops without waiting for a clock).
  - Reset values: state IDLE; `last_seen` 0; `pend`/`pend_v` 0.
  - All outputs 0: `o_lcd_data`, `o_lcd_rs`, `o_lcd_rw`, `o_lcd_en`, `o_lcd_on`, `o_busy`, `o_ovf_cnt`.
  - After release, any nonzero `i_io_lcd[8:0]` counts as a change.

## Timing

Edge k is the rising edge that first samples a new `i_io_lcd[8:0]`.

- After k: `pend_v`=1 and `o_busy`=1.
- After k+1: state SETUP; `o_lcd_data`/`o_lcd_rs` valid.
- EN high after edge k+1+`T_SETUP`, for `T_EN` cycles.
- State HOLD after k+1+`T_SETUP`+`T_EN`.
- State EXEC after a further `T_HOLD` cycles.
- IDLE (and `o_busy`=0 if nothing pending) after k+1+`T_SETUP`+`T_EN`+`T_HOLD`+`T_EXEC`.
- A pending command starts SETUP one cycle after IDLE is re-entered (the IDLE cycle itself).
- Throughput: one command per `T_SETUP`+`T_EN`+`T_HOLD`+`T_EXEC`+1 cycles.
- `o_lcd_on` lags `i_io_lcd[31]` by one cycle.

## Test plan

All scenarios use parameters (2,4,2,10).

- **Reset:** hold `i_reset`=0 with `i_io_lcd`=0x8000_0141 → all outputs 0. Release, first edge k → data=0x41 and rs=1 after k+1; EN high for edges k+3..k+6; `o_busy` low after k+19.
- **Reset mid-pulse:** assert `i_reset`=0 during PULSE → `o_lcd_en`=0 asynchronously, all outputs 0. After release with the same input, a new transaction starts.
- **Back-to-back:** write 0x8000_0041, then 0x8000_0042 during PULSE → both issued in order. Second SETUP starts exactly one cycle after the first returns to IDLE; `o_ovf_cnt`=0.
- **Overflow:** write A=0x8000_0030, then B, C, D (0x31, 0x32, 0x33) while busy → only 0x30 and 0x33 reach `o_lcd_data` with EN pulses; `o_ovf_cnt`=2. Repeat 300 overwrites → saturates at 255.
- **No change:** rewrite the identical value, or change only bits [30:9] → no EN pulse, `o_busy` stays 0.
- **ON gating:** write 0x0000_0155 (ON=0) → no EN pulse, `o_lcd_on`=0. Then write 0x8000_0155 → `o_lcd_on`=1 one cycle later, no EN pulse. Then write 0x8000_0156 → one transaction with rs=1, data=0x56.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style write sequencer driven by a memory-mapped LCD register.
// It keeps one pending command (newest wins) and counts commands overwritten before issue.
module lcd_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic [7:0]  o_ovf_cnt
);
  localparam int T_M1  = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int T_M2  = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

  state_t        r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [8:0]    r_last, r_pend;
  logic          r_pend_v;
  logic [7:0]    r_data, r_ovf;
  logic          r_rs, r_en, r_on;
  logic          w_on, w_chg, w_consume, w_load, w_en_nxt;
  logic          w_unused;

  assign w_on      = i_io_lcd[31];
  assign w_chg     = (i_io_lcd[8:0] != r_last);
  assign w_consume = (r_state == S_IDLE) && r_pend_v && w_on;
  assign w_unused  = ^i_io_lcd[30:9];

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // Next-state logic
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      S_IDLE:  if (w_consume) begin w_nstate = S_SETUP; w_ncnt = CW'(T_SETUP - 1); end
      S_SETUP: if (r_cnt == '0) begin w_nstate = S_PULSE; w_ncnt = CW'(T_EN - 1); end
               else w_ncnt = r_cnt - 1'b1;
      S_PULSE: if (r_cnt == '0) begin w_nstate = S_HOLD; w_ncnt = CW'(T_HOLD - 1); end
               else w_ncnt = r_cnt - 1'b1;
      S_HOLD:  if (r_cnt == '0) begin w_nstate = S_EXEC; w_ncnt = CW'(T_EXEC - 1); end
               else w_ncnt = r_cnt - 1'b1;
      S_EXEC:  if (r_cnt == '0) w_nstate = S_IDLE;
               else w_ncnt = r_cnt - 1'b1;
      default: begin w_nstate = S_IDLE; w_ncnt = '0; end
    endcase
  end

  // Output decode; EN is registered from the next state so it is high exactly in PULSE
  always_comb begin
    w_load   = (r_state == S_IDLE) && (w_nstate == S_SETUP);
    w_en_nxt = (w_nstate == S_PULSE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_data <= '0;
      r_rs   <= 1'b0;
      r_en   <= 1'b0;
      r_on   <= 1'b0;
    end else begin
      r_en <= w_en_nxt;
      r_on <= w_on;
      if (w_load) begin
        r_data <= r_pend[7:0];
        r_rs   <= r_pend[8];
      end
    end
  end

  // Change capture into the single pending slot; a capture in the consume cycle is not an overwrite
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_ovf    <= '0;
    end else begin
      r_last <= i_io_lcd[8:0];
      if (!w_on) begin
        r_pend_v <= 1'b0;
      end else if (w_chg) begin
        r_pend   <= i_io_lcd[8:0];
        r_pend_v <= 1'b1;
        if (r_pend_v && !w_consume && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
      end else if (w_consume) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_on   = r_on;
  assign o_busy     = (r_state != S_IDLE) || r_pend_v;
  assign o_ovf_cnt  = r_ovf;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with timing (2,4,2,10): one transaction spans 19 cycles after capture.
module tb_lcd_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io = '0;
  logic [7:0]  lcd_data, ovf_cnt;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy;

  int n_chk = 0, n_err = 0;
  int cyc = 0, en_hi = 0;
  logic prev_en = 1'b0;
  int rises[$];
  logic [8:0] rdata[$];

  always #5 clk = ~clk;

  lcd_ctrl #(.T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_EXEC(10)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_io_lcd(io),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on), .o_busy(busy), .o_ovf_cnt(ovf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and log EN rising edges with the bus value they strobe
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (lcd_en) en_hi++;
    if (lcd_en && !prev_en) begin
      rises.push_back(cyc);
      rdata.push_back({lcd_rs, lcd_data});
    end
    prev_en = lcd_en;
  endtask

  task automatic clr();
    cyc = 0; en_hi = 0;
    rises.delete(); rdata.delete();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic int rise_at(input int i);
    return (i < rises.size()) ? rises[i] : -1;
  endfunction

  function automatic logic [8:0] data_at(input int i);
    return (i < rdata.size()) ? rdata[i] : 9'h1FF;
  endfunction

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".data"}, lcd_data, 0);
    chk({tag, ".rs"},   lcd_rs, 0);
    chk({tag, ".rw"},   lcd_rw, 0);
    chk({tag, ".en"},   lcd_en, 0);
    chk({tag, ".on"},   lcd_on, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".ovf"},  ovf_cnt, 0);
  endtask

  // Called right after edge k; checks a lone transaction through to IDLE
  task automatic single_txn(input string tag, input logic [8:0] cmd);
    clr();
    tick();
    chk({tag, ".data_k1"}, {lcd_rs, lcd_data}, cmd);
    run_to(18);
    chk({tag, ".busy_k18"}, busy, 1);
    tick();
    chk({tag, ".busy_k19"}, busy, 0);
    chk({tag, ".nrise"}, rises.size(), 1);
    chk({tag, ".rise"}, rise_at(0), 3);
    chk({tag, ".en_len"}, en_hi, 4);
    chk({tag, ".cmd"}, data_at(0), cmd);
  endtask

  initial begin
    // Reset with a command already present
    io = 32'h8000_0141;
    repeat (3) tick();
    chk_outs_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("rst.busy_k", busy, 1);
    chk("rst.on_k", lcd_on, 1);
    single_txn("rst", 9'h141);

    // Asynchronous reset during PULSE
    io = 32'h8000_0177;
    tick();
    clr();
    repeat (3) tick();
    chk("mid.en_pulse", lcd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_outs_zero("mid");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid.busy_k", busy, 1);
    single_txn("mid", 9'h177);

    // Back-to-back: second command written during the first pulse
    io = 32'h8000_0041;
    tick();
    clr();
    run_to(3);
    io = 32'h8000_0042;
    run_to(19);
    chk("b2b.busy_idle", busy, 1);
    tick();
    chk("b2b.data2", {lcd_rs, lcd_data}, 9'h042);
    run_to(37);
    chk("b2b.busy_k37", busy, 1);
    tick();
    chk("b2b.busy_k38", busy, 0);
    chk("b2b.nrise", rises.size(), 2);
    chk("b2b.rise0", rise_at(0), 3);
    chk("b2b.rise1", rise_at(1), 22);
    chk("b2b.cmd0", data_at(0), 9'h041);
    chk("b2b.cmd1", data_at(1), 9'h042);
    chk("b2b.en_len", en_hi, 8);
    chk("b2b.ovf", ovf_cnt, 0);

    // Overflow: B fills the empty slot, C and D overwrite
    io = 32'h8000_0030;
    tick();
    clr();
    run_to(2);
    io = 32'h8000_0031; tick();
    io = 32'h8000_0032; tick();
    io = 32'h8000_0033; tick();
    run_to(50);
    chk("ovf.nrise", rises.size(), 2);
    chk("ovf.cmd0", data_at(0), 9'h030);
    chk("ovf.cmd1", data_at(1), 9'h033);
    chk("ovf.cnt", ovf_cnt, 2);
    chk("ovf.busy", busy, 0);
    for (int i = 0; i < 300; i++) begin
      io = (i % 2 == 0) ? 32'h8000_0034 : 32'h8000_0035;
      tick();
    end
    chk("ovf.sat", ovf_cnt, 255);
    repeat (45) tick();
    chk("ovf.sat_hold", ovf_cnt, 255);
    chk("ovf.busy_end", busy, 0);

    // No change: identical rewrite, then only ignored bits toggled
    clr();
    io = 32'h8000_0035;
    repeat (5) tick();
    io = 32'hFFFF_FE35;
    tick();
    chk("nochg.busy", busy, 0);
    repeat (25) tick();
    chk("nochg.nrise", rises.size(), 0);
    chk("nochg.busy_end", busy, 0);
    chk("nochg.on", lcd_on, 1);

    // ON gating
    clr();
    io = 32'h0000_0155;
    tick();
    chk("on.off_busy", busy, 0);
    chk("on.off", lcd_on, 0);
    repeat (20) tick();
    io = 32'h8000_0155;
    chk("on.lag", lcd_on, 0);
    tick();
    chk("on.rise", lcd_on, 1);
    repeat (20) tick();
    chk("on.nrise", rises.size(), 0);
    chk("on.busy", busy, 0);
    io = 32'h8000_0156;
    tick();
    single_txn("on", 9'h156);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
